// File: rtl/dmem_router.sv
// N-target address router for the core data-memory pipeconnect port.
// Request layout {R, W, A[31:0], WD[31:0], WBE[3:0]}; response layout {HOLD, RD[31:0]}.
module dmem_router #(
   parameter int          NTARGET  = 2,
   parameter logic [31:0] BASE0    = 32'h1000_0000,
   parameter logic [31:0] BASE1    = 32'h0000_0000,
   parameter logic [31:0] BASE2    = 32'h0000_0000,
   parameter logic [31:0] BASE3    = 32'h0000_0000,
   parameter logic [31:0] MASK0    = 32'hFFFF_E000,
   parameter logic [31:0] MASK1    = 32'h0000_0000,
   parameter logic [31:0] MASK2    = 32'h0000_0000,
   parameter logic [31:0] MASK3    = 32'h0000_0000,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
   parameter bit          debug    = 1'b0,
   localparam int         REQ_W    = 70,
   localparam int         RES_W    = 33
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [REQ_W-1:0]           dmem_req,
   output logic [RES_W-1:0]           dmem_res,
   output logic [NTARGET*REQ_W-1:0]   tgt_req,
   input  logic [NTARGET*RES_W-1:0]   tgt_res,
   input  logic                       err_clr,
   output logic                       err_valid,
   output logic [31:0]                err_addr,
   output logic [15:0]                err_count
);

   logic        req_r, req_w;
   logic [31:0] req_a;
   logic [1:0]  cur;
   logic        mapped;
   logic        hold;
   logic [31:0] rd;
   logic        unused_debug;

   logic [1:0]  sel_q, sel_d;
   logic        pend_q, pend_d;
   logic        unm_q, unm_d;
   logic        err_valid_q, err_valid_d;
   logic [31:0] err_addr_q, err_addr_d;
   logic [15:0] err_count_q, err_count_d;

   logic [RES_W-1:0] res_a [4];

   assign req_r        = dmem_req[69];
   assign req_w        = dmem_req[68];
   assign req_a        = dmem_req[67:36];
   assign unused_debug = debug;

   function automatic logic win_hit(input int idx, input logic [31:0] a);
      case (idx)
         0:       win_hit = (a & MASK0) == BASE0;
         1:       win_hit = (a & MASK1) == BASE1;
         2:       win_hit = (a & MASK2) == BASE2;
         3:       win_hit = (a & MASK3) == BASE3;
         default: win_hit = 1'b0;
      endcase
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Unused response slots read as idle so a 2-bit select never indexes past the array.
   for (genvar g = 0; g < 4; g++) begin : g_res
      if (g < NTARGET) begin : g_used
         assign res_a[g] = tgt_res[g*RES_W +: RES_W];
      end else begin : g_idle
         assign res_a[g] = '0;
      end
   end

   // Scanning downward lets the lowest-index hit overwrite any higher one.
   always_comb begin
      cur    = 2'd0;
      mapped = 1'b0;
      for (int i = NTARGET - 1; i >= 0; i--) begin
         if (win_hit(i, req_a)) begin
            cur    = 2'(i);
            mapped = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NTARGET; g++) begin : g_fwd
      logic fwd;
      assign fwd = rst & mapped & (cur == 2'(g));
      assign tgt_req[g*REQ_W +: REQ_W] = {req_r & fwd, req_w & fwd, dmem_req[67:0]};
   end

   assign hold = rst & ((pend_q & ~unm_q & res_a[sel_q][32]) |
                        ((req_r | req_w) & mapped & res_a[cur][32]));
   assign rd   = pend_q ? (unm_q ? ERR_DATA : res_a[sel_q][31:0]) : 32'd0;

   assign dmem_res  = {hold, rd};
   assign err_valid = err_valid_q;
   assign err_addr  = err_addr_q;
   assign err_count = err_count_q;

   always_comb begin
      sel_d       = sel_q;
      pend_d      = pend_q;
      unm_d       = unm_q;
      err_valid_d = err_valid_q;
      err_addr_d  = err_addr_q;
      err_count_d = err_count_q;
      if (!hold) begin
         pend_d = req_r;
         sel_d  = cur;
         unm_d  = req_r & ~mapped;
      end
      // A new unmapped access in the same cycle as a clear restarts the log with itself.
      if ((req_r | req_w) & ~mapped & ~hold) begin
         err_count_d = err_clr ? 16'd1 : sat_inc(err_count_q);
         if (err_clr || !err_valid_q) err_addr_d = req_a;
         err_valid_d = 1'b1;
      end else if (err_clr) begin
         err_count_d = 16'd0;
         err_addr_d  = 32'd0;
         err_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_q       <= 2'd0;
         pend_q      <= 1'b0;
         unm_q       <= 1'b0;
         err_valid_q <= 1'b0;
         err_addr_q  <= 32'd0;
         err_count_q <= 16'd0;
      end else begin
         sel_q       <= sel_d;
         pend_q      <= pend_d;
         unm_q       <= unm_d;
         err_valid_q <= err_valid_d;
         err_addr_q  <= err_addr_d;
         err_count_q <= err_count_d;
      end
   end

endmodule

// File: tb/tb_dmem_router.sv
// Randomized scoreboard bench for dmem_router with three targets, one of which never decodes.
module tb_dmem_router;

   localparam int          NT  = 3;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;
   localparam logic [31:0] TB_BASE [3] = '{32'h1000_0000, 32'h0000_0000, 32'h0000_0001};
   localparam logic [31:0] TB_MASK [3] = '{32'hFFFF_E000, 32'hC000_0000, 32'h0000_0000};

   logic              clk;
   logic              rst;
   logic              req_r, req_w;
   logic [31:0]       req_a, req_wd;
   logic [3:0]        req_wbe;
   logic [69:0]       dmem_req;
   logic [32:0]       dmem_res;
   logic [NT*70-1:0]  tgt_req;
   logic [NT*33-1:0]  tgt_res;
   logic              err_clr_s;
   logic              err_valid;
   logic [31:0]       err_addr;
   logic [15:0]       err_count;

   logic [2:0]        tgt_hold;
   logic [31:0]       tgt_rd [NT];

   // reference model state
   bit                exp_hold;
   bit                m_pend, m_unm;
   int                m_sel;
   bit                m_ev;
   logic [31:0]       m_ea;
   logic [15:0]       m_ec;
   logic [31:0]       q [$];
   bit                in_rst, started;

   int checks = 0;
   int errors = 0;

   assign dmem_req = {req_r, req_w, req_a, req_wd, req_wbe};

   always_comb begin
      tgt_res = '0;
      for (int i = 0; i < NT; i++) tgt_res[i*33 +: 33] = {tgt_hold[i], tgt_rd[i]};
   end

   dmem_router #(
      .NTARGET(NT),
      .BASE0(32'h1000_0000), .MASK0(32'hFFFF_E000),
      .BASE1(32'h0000_0000), .MASK1(32'hC000_0000),
      .BASE2(32'h0000_0001), .MASK2(32'h0000_0000),
      .ERR_DATA(ERR)
   ) dut (
      .clk(clk), .rst(rst),
      .dmem_req(dmem_req), .dmem_res(dmem_res),
      .tgt_req(tgt_req), .tgt_res(tgt_res),
      .err_clr(err_clr_s), .err_valid(err_valid),
      .err_addr(err_addr), .err_count(err_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void decode(input logic [31:0] a, output int c, output bit mp);
      c  = 0;
      mp = 1'b0;
      for (int i = 0; i < NT; i++) begin
         if (!mp && ((a & TB_MASK[i]) == TB_BASE[i])) begin
            c  = i;
            mp = 1'b1;
         end
      end
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] act_rw();
      logic [5:0] v;
      for (int i = 0; i < NT; i++) v[2*i +: 2] = {tgt_req[i*70+69], tgt_req[i*70+68]};
      return v;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_hold"}, 64'(dmem_res[32]), 64'd0);
      chk({tag, "_rd"}, 64'(dmem_res[31:0]), 64'd0);
      chk({tag, "_fwd_rw"}, 64'(act_rw()), 64'd0);
      chk({tag, "_err"}, {15'd0, err_valid, err_addr, err_count}, 64'd0);
   endtask

   // One clock: account for the edge just passed, then present the next cycle's inputs.
   task automatic tick(input bit r, input bit w, input logic [31:0] a,
                       input logic [2:0] h, input bit clr);
      int         c;
      bit         mp, acc;
      logic [31:0] d;
      @(negedge clk);
      acc = !exp_hold;
      decode(req_a, c, mp);
      if (acc && (req_r || req_w) && !mp) begin
         m_ec = err_clr_s ? 16'd1 : ((m_ec == 16'hFFFF) ? m_ec : m_ec + 16'd1);
         if (err_clr_s || !m_ev) m_ea = req_a;
         m_ev = 1'b1;
      end else if (err_clr_s) begin
         m_ec = 16'd0;
         m_ea = 32'd0;
         m_ev = 1'b0;
      end
      if (acc) begin
         for (int i = 0; i < NT; i++) tgt_rd[i] = $urandom;
         m_pend = req_r;
         m_sel  = c;
         m_unm  = req_r && !mp;
         if (req_r) begin
            if (mp) begin
               d = $urandom;
               tgt_rd[c] = d;
               q.push_back(d);
            end else begin
               q.push_back(ERR);
            end
         end
         req_r   = r;
         req_w   = w;
         req_a   = a;
         req_wd  = $urandom;
         req_wbe = 4'($urandom);
      end else begin
         for (int i = 0; i < NT; i++)
            if (!(m_pend && !m_unm && i == m_sel)) tgt_rd[i] = $urandom;
      end
      tgt_hold  = h;
      err_clr_s = clr;
      decode(req_a, c, mp);
      exp_hold = (m_pend && !m_unm && tgt_hold[m_sel]) || ((req_r || req_w) && mp && tgt_hold[c]);
   endtask

   task automatic rand_tick();
      int         k;
      bit         r, w;
      logic [31:0] a;
      logic [2:0] h;
      k = $urandom_range(0, 99);
      r = (k < 40);
      w = (k >= 40) && (k < 65);
      case ($urandom_range(0, 3))
         0:       a = 32'h1000_0000 | ($urandom & 32'h0000_1FFC);
         1:       a = $urandom & 32'h3FFF_FFFC;
         2:       a = 32'h4000_0000 | $urandom;
         default: a = 32'h1000_1000 | ($urandom & 32'h0000_0FFC);
      endcase
      for (int i = 0; i < 3; i++) h[i] = ($urandom_range(0, 3) == 0);
      tick(r, w, a, h, $urandom_range(0, 24) == 0);
   endtask

   // Monitor: compares every cycle just before the active edge.
   initial begin
      int         c;
      bit         mp;
      logic [5:0] erw;
      logic [31:0] e;
      forever begin
         @(negedge clk);
         #4;
         if (started && !in_rst && rst) begin
            chk("hold", 64'(dmem_res[32]), 64'(exp_hold));
            decode(req_a, c, mp);
            erw = '0;
            if (mp) erw[2*c +: 2] = {req_r, req_w};
            chk("fwd_rw", 64'(act_rw()), 64'(erw));
            for (int i = 0; i < NT; i++)
               chk($sformatf("fwd_a%0d", i), 64'(tgt_req[i*70+36 +: 32]), 64'(req_a));
            chk("err_valid", 64'(err_valid), 64'(m_ev));
            chk("err_addr", 64'(err_addr), 64'(m_ea));
            chk("err_count", 64'(err_count), 64'(m_ec));
            if (q.size() > 0) begin
               if (dmem_res[32] == 1'b0) begin
                  e = q.pop_front();
                  chk("rd", 64'(dmem_res[31:0]), 64'(e));
               end
            end else begin
               chk("rd_idle", 64'(dmem_res[31:0]), 64'd0);
            end
         end
      end
   end

   initial begin
      rst = 1'b0; started = 1'b0; in_rst = 1'b0;
      req_r = 1'b1; req_w = 1'b0; req_a = 32'h1000_0004; req_wd = '0; req_wbe = '0;
      tgt_hold = 3'b111; err_clr_s = 1'b0;
      for (int i = 0; i < NT; i++) tgt_rd[i] = 32'h1234;
      m_pend = 0; m_unm = 0; m_sel = 0; m_ev = 0; m_ea = '0; m_ec = '0; exp_hold = 0;
      #3;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b1; req_r = 1'b0; tgt_hold = 3'b000; exp_hold = 1'b0; started = 1'b1;

      tick(1, 0, 32'h1000_0004, 3'b000, 0);   // tgt0 read
      tick(1, 0, 32'h2000_0000, 3'b000, 0);   // back-to-back tgt1 read
      tick(1, 0, 32'h1000_1000, 3'b000, 0);   // overlap: tgt0 wins
      tick(0, 0, 32'h0, 3'b001, 0);           // pending tgt0 read stalls 3 cycles
      tick(0, 0, 32'h0, 3'b001, 0);
      tick(0, 0, 32'h0, 3'b001, 0);
      tick(1, 0, 32'h2000_0004, 3'b000, 0);
      tick(0, 0, 32'h0, 3'b010, 0);           // tgt1 stalls pending read
      tick(0, 0, 32'h0, 3'b010, 0);
      tick(0, 0, 32'h0, 3'b010, 0);
      tick(1, 0, 32'h8000_0000, 3'b000, 0);   // unmapped read -> ERR
      tick(0, 1, 32'h8000_0000, 3'b111, 0);   // unmapped write never stalls
      tick(0, 1, 32'hC000_0008, 3'b000, 1);   // clear and new error together
      tick(0, 1, 32'h1000_0008, 3'b001, 1);   // mapped write stalled by its target
      tick(0, 0, 32'h0, 3'b000, 0);

      for (int n = 0; n < 1500; n++) rand_tick();

      tick(1, 0, 32'h1000_0010, 3'b000, 0);
      tick(1, 0, 32'h2000_0000, 3'b111, 0);
      @(negedge clk);
      in_rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      check_reset_outputs("midreset");
      q.delete();
      m_pend = 0; m_unm = 0; m_sel = 0; m_ev = 0; m_ea = '0; m_ec = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; req_r = 1'b0; req_w = 1'b0; tgt_hold = 3'b000; err_clr_s = 1'b0;
      exp_hold = 1'b0; in_rst = 1'b0;
      tick(1, 0, 32'h2000_0008, 3'b000, 0);
      tick(1, 0, 32'h1000_0020, 3'b000, 0);

      for (int n = 0; n < 400; n++) rand_tick();

      tick(0, 0, 32'h0, 3'b000, 0);
      tick(0, 0, 32'h0, 3'b000, 0);
      tick(0, 0, 32'h0, 3'b000, 0);
      @(negedge clk);
      #4;
      chk("drain", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
